// File: rtl/riscv_mem_pkg.sv
// Shared types for the unified-memory port arbiter.
// funct3 encodings, arbiter states and grant identifiers.
package riscv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    IF_RESP,
    D_RESP
  } state_t;

  typedef enum logic {
    GNT_IF,
    GNT_D
  } gnt_t;

endpackage

// File: rtl/lsu_align.sv
// RV32I load/store lane steering, extension and access checks.
// Purely combinational; request side and response side are independent.
module lsu_align
  import riscv_mem_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic        err,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  logic [31:0] shifted;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    err = 1'b0;
    case (funct3)
      F3_B:    err = 1'b0;
      F3_H:    err = addr[0];
      F3_W:    err = |addr;
      F3_BU:   err = we;
      F3_HU:   err = we | addr[0];
      default: err = 1'b1;
    endcase
  end

  always_comb begin
    be         = 4'b0000;
    wdata_lane = 32'h0;
    case (funct3[1:0])
      2'b00: begin
        be         = 4'b0001 << addr;
        wdata_lane = {4{wdata[7:0]}};
      end
      2'b01: begin
        be         = addr[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata[15:0]}};
      end
      default: begin
        be         = 4'b1111;
        wdata_lane = wdata;
      end
    endcase
  end

  assign shifted = rdata >> {ld_addr, 3'b000};
  assign lane_b  = shifted[7:0];
  assign lane_h  = ld_addr[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    ld_data = 32'h0;
    case (ld_funct3)
      F3_B:    ld_data = {{24{lane_b[7]}}, lane_b};
      F3_H:    ld_data = {{16{lane_h[15]}}, lane_h};
      F3_W:    ld_data = rdata;
      F3_BU:   ld_data = {24'h0, lane_b};
      F3_HU:   ld_data = {16'h0, lane_h};
      default: ld_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between
// instruction fetch and load/store, with 1-cycle read latency.
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [31:0]   if_addr,
  output logic [31:0]   if_rdata,
  output logic          if_valid,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [31:0]   d_addr,
  input  logic [2:0]    d_funct3,
  input  logic [31:0]   d_wdata,
  output logic [31:0]   d_rdata,
  output logic          d_valid,
  output logic          d_err,
  output logic [AW-1:0] mem_addr,
  output logic [3:0]    mem_we,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  state_t      state_q, state_d;
  gnt_t        last_q, last_d;
  logic        d_we_q, d_err_q;
  logic [2:0]  d_f3_q;
  logic [1:0]  d_lo_q;
  logic        gnt_if, gnt_d;
  logic        d_bad;
  logic [3:0]  be;
  logic [31:0] wlane, ld_data;

  lsu_align u_lsu (
    .we         (d_we),
    .funct3     (d_funct3),
    .addr       (d_addr[1:0]),
    .wdata      (d_wdata),
    .err        (d_bad),
    .be         (be),
    .wdata_lane (wlane),
    .ld_funct3  (d_f3_q),
    .ld_addr    (d_lo_q),
    .rdata      (mem_rdata),
    .ld_data    (ld_data)
  );

  // No grant while reset is held, so nothing reaches memory then.
  always_comb begin
    gnt_if = 1'b0;
    gnt_d  = 1'b0;
    if (state_q == IDLE && reset) begin
      if (if_req && d_req) begin
        gnt_if = (last_q == GNT_D);
        gnt_d  = (last_q == GNT_IF);
      end else begin
        gnt_if = if_req;
        gnt_d  = d_req;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    mem_addr  = '0;
    mem_we    = 4'b0000;
    mem_wdata = 32'h0;
    if_rdata  = 32'h0;
    if_valid  = 1'b0;
    d_rdata   = 32'h0;
    d_valid   = 1'b0;
    d_err     = 1'b0;
    unique case (1'b1)
      gnt_if: begin
        mem_addr = if_addr[AW+1:2];
        state_d  = IF_RESP;
        last_d   = GNT_IF;
      end
      gnt_d: begin
        mem_addr = d_addr[AW+1:2];
        if (d_we && !d_bad) begin
          mem_we    = be;
          mem_wdata = wlane;
        end
        state_d = D_RESP;
        last_d  = GNT_D;
      end
      (state_q == IF_RESP): begin
        if_rdata = mem_rdata;
        if_valid = 1'b1;
        state_d  = IDLE;
      end
      (state_q == D_RESP): begin
        d_valid = 1'b1;
        d_err   = d_err_q;
        d_rdata = (d_err_q || d_we_q) ? 32'h0 : ld_data;
        state_d = IDLE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= GNT_D;
      d_we_q  <= 1'b0;
      d_err_q <= 1'b0;
      d_f3_q  <= 3'b000;
      d_lo_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      if (gnt_d) begin
        d_we_q  <= d_we;
        d_err_q <= d_bad;
        d_f3_q  <= d_funct3;
        d_lo_q  <= d_addr[1:0];
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a behavioural
// registered-read memory behind the arbiter.
module tb_mem_port_arbiter;
  import riscv_mem_pkg::*;

  localparam int AW = 11;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          if_req = 1'b0;
  logic [31:0]   if_addr = '0;
  logic [31:0]   if_rdata;
  logic          if_valid;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [31:0]   d_addr = '0;
  logic [2:0]    d_funct3 = '0;
  logic [31:0]   d_wdata = '0;
  logic [31:0]   d_rdata;
  logic          d_valid;
  logic          d_err;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_we;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = '0;

  logic [31:0] mem [0:(2**AW)-1];

  typedef struct {
    logic        is_d;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_v = -1;
  bit spacing = 1'b0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_valid  (if_valid),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_funct3  (d_funct3),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_valid   (d_valid),
    .d_err     (d_err),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (mem_we[i])
        mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
    mem_rdata <= mem[mem_addr];
    cyc <= cyc + 1;
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset && (if_valid || d_valid)) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got if=%b d=%b want none",
                 if_valid, d_valid);
      end else begin
        e = q.pop_front();
        chk("port_is_d", 32'(d_valid), 32'(e.is_d));
        if (d_valid) begin
          chk("d_rdata", d_rdata, e.rdata);
          chk("d_err", 32'(d_err), 32'(e.err));
        end else begin
          chk("if_rdata", if_rdata, e.rdata);
        end
        if (spacing && last_v >= 0)
          chk("valid_spacing", 32'(cyc - last_v), 32'd2);
        last_v = cyc;
      end
    end
  end

  task automatic fetch(input logic [31:0] a,
                       input logic [31:0] exp_rd);
    @(negedge clk);
    if_req  = 1'b1;
    if_addr = a;
    q.push_back('{1'b0, exp_rd, 1'b0});
    #1;
    chk("f_mem_addr", 32'(mem_addr), 32'(a[AW+1:2]));
    chk("f_mem_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    if_req = 1'b0;
  endtask

  task automatic dacc(input logic        we,
                      input logic [2:0]  f3,
                      input logic [31:0] a,
                      input logic [31:0] wd,
                      input logic [3:0]  exp_we,
                      input logic [31:0] exp_wd,
                      input logic [31:0] exp_rd,
                      input logic        exp_err);
    @(negedge clk);
    d_req    = 1'b1;
    d_we     = we;
    d_funct3 = f3;
    d_addr   = a;
    d_wdata  = wd;
    q.push_back('{1'b1, exp_rd, exp_err});
    #1;
    chk("d_mem_addr", 32'(mem_addr), 32'(a[AW+1:2]));
    chk("d_mem_we", 32'(mem_we), 32'(exp_we));
    if (exp_we != 4'b0000)
      chk("d_mem_wdata", mem_wdata, exp_wd);
    @(negedge clk);
    d_req = 1'b0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_if_valid"}, 32'(if_valid), 32'd0);
    chk({tag, "_d_valid"}, 32'(d_valid), 32'd0);
    chk({tag, "_d_err"}, 32'(d_err), 32'd0);
    chk({tag, "_if_rdata"}, if_rdata, 32'd0);
    chk({tag, "_d_rdata"}, d_rdata, 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_quiet("rst");
    reset = 1'b1;

    dacc(1, F3_W, 32'h10, 32'h13, 4'hF, 32'h13, 0, 0);
    dacc(1, F3_W, 32'h20, 32'h80FF7F01, 4'hF, 32'h80FF7F01, 0, 0);
    dacc(1, F3_W, 32'h40, 32'h0, 4'hF, 32'h0, 0, 0);
    dacc(1, F3_W, 32'h44, 32'h0, 4'hF, 32'h0, 0, 0);

    fetch(32'h10, 32'h00000013);
    fetch(32'h13, 32'h00000013);

    dacc(0, F3_B,  32'h21, 0, 4'h0, 0, 32'h0000007F, 0);
    dacc(0, F3_BU, 32'h21, 0, 4'h0, 0, 32'h0000007F, 0);
    dacc(0, F3_H,  32'h22, 0, 4'h0, 0, 32'hFFFF80FF, 0);
    dacc(0, F3_HU, 32'h22, 0, 4'h0, 0, 32'h000080FF, 0);
    dacc(0, F3_B,  32'h22, 0, 4'h0, 0, 32'hFFFFFFFF, 0);
    dacc(0, F3_BU, 32'h23, 0, 4'h0, 0, 32'h00000080, 0);
    dacc(0, F3_H,  32'h20, 0, 4'h0, 0, 32'h00007F01, 0);
    dacc(0, F3_W,  32'h20, 0, 4'h0, 0, 32'h80FF7F01, 0);

    dacc(1, F3_B, 32'h43, 32'hFFFFFFAB,
         4'b1000, 32'hABABABAB, 0, 0);
    dacc(1, F3_H, 32'h46, 32'hDEAD1234,
         4'b1100, 32'h12341234, 0, 0);
    dacc(0, F3_W, 32'h40, 0, 4'h0, 0, 32'hAB000000, 0);

    // last grant was data, so fetch must win the first tie
    @(negedge clk);
    if_req   = 1'b1;
    if_addr  = 32'h10;
    d_req    = 1'b1;
    d_we     = 1'b0;
    d_funct3 = F3_W;
    d_addr   = 32'h44;
    q.push_back('{1'b0, 32'h00000013, 1'b0});
    q.push_back('{1'b1, 32'h12340000, 1'b0});
    q.push_back('{1'b0, 32'h00000013, 1'b0});
    q.push_back('{1'b1, 32'h12340000, 1'b0});
    spacing = 1'b1;
    last_v  = -1;
    repeat (7) @(negedge clk);
    if_req = 1'b0;
    d_req  = 1'b0;
    @(negedge clk);
    spacing = 1'b0;
    chk("contention_drain", 32'(q.size()), 32'd0);

    dacc(0, F3_W,   32'h102, 0, 4'h0, 0, 0, 1);
    dacc(0, 3'b011, 32'h40,  0, 4'h0, 0, 0, 1);
    dacc(0, F3_HU,  32'h21,  0, 4'h0, 0, 0, 1);
    dacc(1, F3_H,   32'h45, 32'h5555, 4'h0, 0, 0, 1);
    dacc(1, F3_BU,  32'h40, 32'h77,   4'h0, 0, 0, 1);
    dacc(1, F3_W,   32'h42, 32'h99,   4'h0, 0, 0, 1);
    dacc(0, F3_W,   32'h40, 0, 4'h0, 0, 32'hAB000000, 0);

    @(negedge clk);
    d_req    = 1'b1;
    d_we     = 1'b0;
    d_funct3 = F3_W;
    d_addr   = 32'h20;
    @(posedge clk);
    #1;
    reset = 1'b0;
    d_req = 1'b0;
    @(negedge clk);
    chk_quiet("midrst");
    @(negedge clk);
    chk("midrst_d_valid2", 32'(d_valid), 32'd0);
    reset = 1'b1;

    fetch(32'h20, 32'h80FF7F01);

    repeat (3) @(negedge clk);
    chk("final_drain", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

endmodule
